axis_tx_frame_arb: RTL

AXIS_TX_FRAME_ARB -- requirements
Module: axis_tx_frame_arb

---
 rtl/axis_tx_frame_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axis_tx_frame_arb.sv
// Round-robin AXI-stream frame arbiter feeding a single GMII transmit stream.
// Whole frames are forwarded; oversize frames are cut at MAX_LEN and the tail dropped.
module axis_tx_frame_arb #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned MAX_LEN    = 1522
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    input  logic [PORTS-1:0]              s_axis_tlast,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic                          enable,
    input  logic                          pause_req,
    output logic                          grant_valid,
    output logic [$clog2(PORTS)-1:0]      grant_index,
    output logic                          frame_done,
    output logic                          frame_truncated
);

    localparam int unsigned IDX_W = $clog2(PORTS);
    localparam logic [15:0] TRUNC_AT = 16'(MAX_LEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_last_grant;
    logic [15:0]           r_beat_cnt;
    logic                  r_grant_valid;
    logic                  r_frame_done;
    logic                  r_frame_truncated;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [USER_WIDTH-1:0] w_sel_user;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_grant;
    logic                  w_trunc_beat;
    logic                  w_pass_xfer;

    assign w_sel_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_user  = s_axis_tuser[r_grant*USER_WIDTH +: USER_WIDTH];
    assign w_sel_valid = s_axis_tvalid[r_grant];
    assign w_sel_last  = s_axis_tlast[r_grant];

    // Round-robin scan starting after the last owner; reverse order so the nearest requester wins.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_pick  = r_last_grant;
        v_idx   = 0;
        for (int k = int'(PORTS); k >= 1; k--) begin
            v_idx = (int'(r_last_grant) + k) % int'(PORTS);
            if (s_axis_tvalid[IDX_W'(v_idx)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(v_idx);
            end
        end
    end

    assign w_grant      = (r_state == IDLE) && enable && !pause_req && w_found;
    assign w_trunc_beat = !w_sel_last && (r_beat_cnt == TRUNC_AT);
    assign w_pass_xfer  = (r_state == PASS) && w_sel_valid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_grant) w_next_state = PASS;
            PASS: begin
                if (w_pass_xfer) begin
                    if (w_sel_last) begin
                        w_next_state = IDLE;
                    end else if (w_trunc_beat) begin
                        w_next_state = DROP;
                    end
                end
            end
            DROP: if (w_sel_valid && w_sel_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Stream mux: the owner is wired straight through while passing, sunk while dropping.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        if (r_state == PASS) begin
            m_axis_tdata           = w_sel_data;
            m_axis_tvalid          = w_sel_valid;
            m_axis_tlast           = w_sel_last | w_trunc_beat;
            m_axis_tuser           = w_sel_user;
            m_axis_tuser[0]        = w_sel_user[0] | w_trunc_beat;
            s_axis_tready[r_grant] = m_axis_tready;
        end else if (r_state == DROP) begin
            s_axis_tready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant           <= '0;
            r_last_grant      <= IDX_W'(PORTS - 1);
            r_beat_cnt        <= '0;
            r_grant_valid     <= 1'b0;
            r_frame_done      <= 1'b0;
            r_frame_truncated <= 1'b0;
        end else begin
            r_frame_done      <= w_pass_xfer && w_sel_last;
            r_frame_truncated <= w_pass_xfer && w_trunc_beat;
            r_grant_valid     <= (w_next_state != IDLE);
            if (w_grant) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_beat_cnt   <= '0;
            end else if (w_pass_xfer && (r_beat_cnt != 16'hFFFF)) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

    assign grant_valid     = r_grant_valid;
    assign grant_index     = r_grant;
    assign frame_done      = r_frame_done;
    assign frame_truncated = r_frame_truncated;

endmodule
